// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: ID/EX hazard inputs and pipeline-control outputs.
// The pipeline drives the master side; hazard_ctrl sits on the slave side.
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_md;
    logic       ex_is_load;
    logic [4:0] ex_wa;
    logic       md_start;
    logic       md_is_div;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_clr;
    logic       stall;
    logic       md_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
               ex_is_load, ex_wa, md_start, md_is_div,
        input  pc_en, ifid_en, idex_clr, stall, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
               ex_is_load, ex_wa, md_start, md_is_div,
        output pc_en, ifid_en, idex_clr, stall, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use and multiply/divide busy stalls.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating 32-bit stall counter output.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
`ifdef HAZARD_STALL_CNT_EN
    hazard_ctrl_if.slave  bus,
    output logic [31:0]   stall_cnt
`else
    hazard_ctrl_if.slave  bus
`endif
);

    logic [3:0] busyCnt_q;
    logic [3:0] busyCnt_d;
    logic       mdBusy;
    logic       loadUseHaz;
    logic       mdHaz;
    logic       stallAll;

    assign mdBusy = (busyCnt_q != 4'd0);

    assign loadUseHaz = bus.ex_is_load && (bus.ex_wa != 5'd0) &&
                        ((bus.id_use_rs && (bus.id_rs == bus.ex_wa)) ||
                         (bus.id_use_rt && (bus.id_rt == bus.ex_wa)));

    // An issue in EX this cycle blocks a dependent MD op in ID before busy is visible.
    assign mdHaz    = bus.id_is_md && (mdBusy || bus.md_start);
    assign stallAll = loadUseHaz || mdHaz;

    assign bus.stall    = stallAll;
    assign bus.pc_en    = !stallAll;
    assign bus.ifid_en  = !stallAll;
    assign bus.idex_clr = stallAll;
    assign bus.md_busy  = mdBusy;

    // A start while already busy is dropped rather than reloading the counter.
    always_comb begin
        busyCnt_d = busyCnt_q;
        if (busyCnt_q != 4'd0) begin
            busyCnt_d = busyCnt_q - 4'd1;
        end else if (bus.md_start) begin
            busyCnt_d = bus.md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busyCnt_q <= 4'd0;
        end else begin
            busyCnt_q <= busyCnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCnt_q;
    logic [31:0] stallCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallAll && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= 32'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs per cycle,
// a monitor pops and compares them mid-cycle on the falling edge.
module tb_hazard_ctrl;

    typedef struct {
        string name;
        logic  expStall;
        logic  expBusy;
        logic  chkBusy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];

    hazard_ctrl_if bus();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] cntBefore;
    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus), .stall_cnt(stallCnt)
    );
`else
    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge and queues what it should produce.
    task automatic applyStimulus(
        input logic [4:0] rs, input logic [4:0] rt, input logic useRs, input logic useRt,
        input logic isMd, input logic exLoad, input logic [4:0] wa,
        input logic mdStart, input logic mdDiv, input logic rst,
        input logic expStall, input logic expBusy, input logic chkBusy, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_use_rs  = useRs;
        bus.id_use_rt  = useRt;
        bus.id_is_md   = isMd;
        bus.ex_is_load = exLoad;
        bus.ex_wa      = wa;
        bus.md_start   = mdStart;
        bus.md_is_div  = mdDiv;
        reset          = rst;
        e.name     = name;
        e.expStall = expStall;
        e.expBusy  = expBusy;
        e.chkBusy  = chkBusy;
        expQ.push_back(e);
    endtask

    task automatic idle(input logic expBusy, input string name);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      1'b0, expBusy, 1'b1, name);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] got;
        logic [3:0] want;
        got  = {bus.stall, bus.pc_en, bus.ifid_en, bus.idex_clr};
        want = {e.expStall, !e.expStall, !e.expStall, e.expStall};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s ctrl {stall,pc_en,ifid_en,idex_clr}: got %b want %b",
                     e.name, got, want);
        end
        if (e.chkBusy) begin
            checks++;
            if (bus.md_busy !== e.expBusy) begin
                errors++;
                $display("[TB] FAIL %s md_busy: got %b want %b", e.name, bus.md_busy, e.expBusy);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        int drain;
        reset = 1'b1;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.id_is_md = 1'b0; bus.ex_is_load = 1'b0; bus.ex_wa = 5'd0;
        bus.md_start = 1'b0; bus.md_is_div = 1'b0;

        // Reset: outputs stay combinational while reset is held.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b0, "rst_idle");
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1,
                      1'b1, 1'b0, 1'b1, "rst_loaduse");
        idle(1'b0, "post_rst_idle");

        // Load-use on rs and rt, and the cases that must not stall.
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b1, "lu_rs8");
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "lu_wa0");
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b1, "lu_rt9");
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "lu_rt_unused");
        applyStimulus(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "lu_noload");

        // Mult with a dependent MD op held in ID: stall on issue plus five busy cycles.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b1, "mult_issue");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b1, $sformatf("mult_busy%0d", i));
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "mult_done");

        // Div with a second start in busy cycle 3 that must be ignored.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0,
                      1'b0, 1'b0, 1'b1, "div_issue");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, (i == 3), 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b1, $sformatf("div_busy%0d", i));
        end
        idle(1'b0, "div_done");

        // Reset in busy cycle 4 of a div, with a start that must be ignored.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0,
                      1'b0, 1'b0, 1'b1, "div2_issue");
        for (int i = 1; i <= 3; i++) begin
            idle(1'b1, $sformatf("div2_busy%0d", i));
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1,
                      1'b0, 1'b1, 1'b1, "div2_rst");
        idle(1'b0, "div2_after_rst");
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "mult2_issue");
        for (int i = 1; i <= 5; i++) begin
            idle(1'b1, $sformatf("mult2_busy%0d", i));
        end
        idle(1'b0, "mult2_done");

        // Both hazards together for three cycles yield one stall per cycle.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, "both_issue");
`ifdef HAZARD_STALL_CNT_EN
        cntBefore = stallCnt;
`endif
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b1, $sformatf("both_stall%0d", i));
        end
        idle(1'b1, "both_busy4");
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if ((stallCnt - cntBefore) !== 32'd3) begin
            errors++;
            $display("[TB] FAIL stall_cnt_delta: got %0d want 3", stallCnt - cntBefore);
        end
`endif
        idle(1'b1, "both_busy5");
        idle(1'b0, "both_done");

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL provide parameter MULT_CYCLES, default 5, meaning busy cycles after a mult/multu issue (legal 1..15).
REQ-002 The block SHALL provide parameter DIV_CYCLES, default 10, meaning busy cycles after a div/divu issue (legal 1..15).
REQ-003 The block SHALL have clk  input  1  clock, all state on posedge.
REQ-004 The block SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have id_rs  input  5  rs field of the instruction in ID.
REQ-006 The block SHALL have id_rt  input  5  rt field of the instruction in ID.
REQ-007 The block SHALL have id_use_rs  input  1  ID instruction reads rs in ID or EX.
REQ-008 The block SHALL have id_use_rt  input  1  ID instruction reads rt in ID or EX.
REQ-009 The block SHALL have id_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL have ex_is_load  input  1  EX instruction is a load.
REQ-011 The block SHALL have ex_wa  input  5  EX instruction destination register.
REQ-012 The block SHALL have md_start  input  1  EX issues mult/div this cycle.
REQ-013 The block SHALL have md_is_div  input  1  qualifies md_start: 1 = div/divu, 0 = mult/multu.
REQ-014 The block SHALL have pc_en  output  1  PC write enable.
REQ-015 The block SHALL have ifid_en  output  1  IF/ID pipeline register enable.
REQ-016 The block SHALL have idex_clr  output  1  ID/EX register clear (bubble insert).
REQ-017 The block SHALL have stall  output  1  combined stall indication.
REQ-018 The block SHALL have md_busy  output  1  multiply/divide unit busy, registered.

Function
REQ-019 Load-use hazard SHALL be: ex_is_load & ex_wa!=0 & ((id_use_rs & id_rs==ex_wa) | (id_use_rt & id_rt==ex_wa)).
REQ-020 MD hazard SHALL be: id_is_md & (md_busy | md_start).
REQ-021 stall SHALL be the OR of both hazards, combinational, same cycle as the inputs.
REQ-022 pc_en and ifid_en SHALL equal !stall; idex_clr SHALL equal stall.
REQ-023 A 4-bit busy counter SHALL load DIV_CYCLES (md_is_div=1) or MULT_CYCLES (md_is_div=0) on the posedge where md_start=1 and the counter is 0.
REQ-024 The counter SHALL decrement by 1 per cycle while nonzero and hold at 0, with no wrap below 0.
REQ-025 md_busy SHALL be 1 exactly when the counter is nonzero: it rises the cycle after md_start and stays high for exactly N cycles.
REQ-026 md_start while the counter is nonzero SHALL be ignored, with no reload and no extension.
REQ-027 On simultaneous load-use and MD hazards, a single stall SHALL be produced; the counter continues decrementing during the stall.

Reset
REQ-028 On reset=1 at posedge, the counter SHALL clear to 0 (md_busy=0 next cycle), including mid-operation; md_start in the same cycle SHALL be ignored.
REQ-029 Combinational outputs SHALL follow REQ-019..022 during reset; after reset with idle inputs, pc_en=1, ifid_en=1, idex_clr=0, stall=0.

Configuration
REQ-030 Macro HAZARD_STALL_CNT_EN, when defined, SHALL add output stall_cnt (32 bits), incremented at each posedge with stall=1, saturating at 0xFFFFFFFF, and cleared by reset.
REQ-031 Without HAZARD_STALL_CNT_EN, port stall_cnt and its counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 ex_is_load=1, ex_wa=8, id_rs=8, id_use_rs=1 -> stall=1, pc_en=0, ifid_en=0, idex_clr=1 in the same cycle; with ex_wa=0 -> stall=0.
REQ-033 md_start=1, md_is_div=0 for one cycle -> md_busy=1 for exactly 5 cycles, starting the next cycle; with id_is_md=1 throughout -> stall=1 on the issue cycle and all 5 busy cycles, 0 after.
REQ-034 div issued (10 cycles), second md_start in busy cycle 3 -> md_busy still falls after 10 cycles total.
REQ-035 reset=1 in busy cycle 4 of a div -> md_busy=0 on the next cycle; a later mult yields 5 busy cycles.
REQ-036 Load-use and MD hazards applied together for 3 cycles -> stall=1 for 3 cycles; with HAZARD_STALL_CNT_EN, stall_cnt increases by exactly 3.
REQ-037 id_use_rt=0, id_rt=ex_wa=9, ex_is_load=1 -> stall=0.
